// File: rtl/mp3_pkg.sv
// Shared definitions for the MP3 playback path: player state encodings,
// SCI command constants and volume defaults common to the sequencer and streamer.
package mp3_pkg;

    typedef enum logic [1:0] {
        PAUSED  = 2'd0,
        PLAYING = 2'd1,
        SWITCH  = 2'd2
    } play_state_e;

    typedef enum logic {
        CIDLE = 1'b0,
        CREQ  = 1'b1
    } cmd_state_e;

    localparam logic [7:0] SCI_WRITE = 8'h02;
    localparam logic [7:0] SCI_VOL   = 8'h0B;

    localparam logic [7:0] VOL_DEFAULT_C = 8'h20;
    localparam logic [7:0] VOL_STEP_C    = 8'h10;
    localparam logic [7:0] VOL_MAX_C     = 8'hF0;

    // SCI write of the volume register, same attenuation on both channels.
    function automatic logic [31:0] sci_vol_word(input logic [7:0] vol);
        return {SCI_WRITE, SCI_VOL, vol, vol};
    endfunction

endpackage

// File: rtl/mp3_play_ctrl_if.sv
// SCI command handshake between the playback sequencer (master) and the
// SDI/SCI streaming engine (slave).
interface mp3_play_ctrl_if;
    logic        cmd_req;
    logic        cmd_ack;
    logic [31:0] cmd_word;

    modport master (output cmd_req, output cmd_word, input cmd_ack);
    modport slave  (input cmd_req, input cmd_word, output cmd_ack);
endinterface

// File: rtl/mp3_vol_cmd.sv
// Volume register with saturating up/down steps and the req/ack engine that
// pushes each new attenuation to the streamer as an SCI write.
module mp3_vol_cmd
    import mp3_pkg::*;
#(
    parameter logic [7:0] VOL_DEFAULT = VOL_DEFAULT_C,
    parameter logic [7:0] VOL_STEP    = VOL_STEP_C,
    parameter logic [7:0] VOL_MAX     = VOL_MAX_C
) (
    input  logic                   clk_1M,
    input  logic                   rst,
    input  logic                   btn_vup,
    input  logic                   btn_vdn,
    mp3_play_ctrl_if.master        cmd,
    output logic [7:0]             volume
);

    cmd_state_e  cst_q, cst_d;
    logic [7:0]  vol_q, vol_d;
    logic        pend_q, pend_d;
    logic [31:0] word_q, word_d;
    logic [8:0]  vol_sum;

    // Next attenuation: vup lowers toward 0, vdn raises toward VOL_MAX, both together cancel.
    always_comb begin
        vol_d   = vol_q;
        vol_sum = {1'b0, vol_q} + {1'b0, VOL_STEP};
        if (btn_vup && !btn_vdn) begin
            vol_d = (vol_q > VOL_STEP) ? (vol_q - VOL_STEP) : 8'h00;
        end else if (btn_vdn && !btn_vup) begin
            vol_d = (vol_sum > {1'b0, VOL_MAX}) ? VOL_MAX : vol_sum[7:0];
        end
    end

    // Request engine: latch a word when idle with a pending change, hold it until ack.
    always_comb begin
        cst_d  = cst_q;
        word_d = word_q;
        pend_d = pend_q;
        case (cst_q)
            CIDLE: begin
                if (pend_q) begin
                    cst_d  = CREQ;
                    word_d = sci_vol_word(vol_q);
                    pend_d = 1'b0;
                end
            end
            CREQ: begin
                if (cmd.cmd_ack) begin
                    cst_d = CIDLE;
                end
            end
            default: cst_d = CIDLE;
        endcase
        // A change that lands while a request is outstanding is resent after the ack.
        if (vol_d != vol_q) begin
            pend_d = 1'b1;
        end
    end

    // State registers; reset schedules the initial volume write.
    always_ff @(posedge clk_1M) begin
        if (!rst) begin
            cst_q  <= CIDLE;
            vol_q  <= VOL_DEFAULT;
            pend_q <= 1'b1;
            word_q <= sci_vol_word(VOL_DEFAULT);
        end else begin
            cst_q  <= cst_d;
            vol_q  <= vol_d;
            pend_q <= pend_d;
            word_q <= word_d;
        end
    end

    assign cmd.cmd_req  = (cst_q == CREQ);
    assign cmd.cmd_word = word_q;
    assign volume       = vol_q;

endmodule

// File: rtl/mp3_play_ctrl.sv
// Playback sequencer: turns button pulses into track select, play/pause gating
// and a timed player soft-reset on every track change; volume is delegated.
module mp3_play_ctrl
    import mp3_pkg::*;
#(
    parameter int         NUM_TRACKS  = 8,
    parameter int         SWITCH_HOLD = 1000,
    parameter logic [7:0] VOL_DEFAULT = VOL_DEFAULT_C,
    parameter logic [7:0] VOL_STEP    = VOL_STEP_C,
    parameter logic [7:0] VOL_MAX     = VOL_MAX_C,
    parameter bit         AUTO_NEXT   = 1'b1
) (
    input  logic            clk_1M,
    input  logic            rst,
    input  logic            btn_play,
    input  logic            btn_next,
    input  logic            btn_prev,
    input  logic            btn_vup,
    input  logic            btn_vdn,
    input  logic            track_end,
    mp3_play_ctrl_if.master cmd,
    output logic [2:0]      music_id,
    output logic            start,
    output logic            player_rst_n,
    output logic [7:0]      volume,
    output logic [1:0]      state_o
);

    localparam int         CNT_W   = (SWITCH_HOLD > 1) ? $clog2(SWITCH_HOLD) : 1;
    localparam logic [2:0] ID_MASK = 3'(NUM_TRACKS - 1);

    play_state_e      state_q, state_d;
    logic [2:0]       id_q, id_d, id_inc, id_dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, prst_n_q;

    // Main sequencer: priority next > prev > track_end > play; SWITCH ignores transport buttons.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        id_inc  = (id_q + 3'd1) & ID_MASK;
        id_dec  = (id_q - 3'd1) & ID_MASK;
        case (state_q)
            PAUSED, PLAYING: begin
                if (btn_next) begin
                    state_d = SWITCH;
                    id_d    = id_inc;
                    cnt_d   = '0;
                end else if (btn_prev) begin
                    state_d = SWITCH;
                    id_d    = id_dec;
                    cnt_d   = '0;
                end else if (track_end && (state_q == PLAYING)) begin
                    if (AUTO_NEXT) begin
                        state_d = SWITCH;
                        id_d    = id_inc;
                        cnt_d   = '0;
                    end else begin
                        state_d = PAUSED;
                    end
                end else if (btn_play) begin
                    state_d = (state_q == PLAYING) ? PAUSED : PLAYING;
                end
            end
            SWITCH: begin
                if (cnt_q == CNT_W'(SWITCH_HOLD - 1)) begin
                    state_d = PLAYING;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = PAUSED;
        endcase
    end

    // Registered state plus start/player_rst_n derived from the next state so they track it exactly.
    always_ff @(posedge clk_1M) begin
        if (!rst) begin
            state_q  <= PAUSED;
            id_q     <= 3'd0;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            prst_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            start_q  <= (state_d == PLAYING);
            prst_n_q <= (state_d != SWITCH);
        end
    end

    mp3_vol_cmd #(
        .VOL_DEFAULT (VOL_DEFAULT),
        .VOL_STEP    (VOL_STEP),
        .VOL_MAX     (VOL_MAX)
    ) u_vol_cmd (
        .clk_1M  (clk_1M),
        .rst     (rst),
        .btn_vup (btn_vup),
        .btn_vdn (btn_vdn),
        .cmd     (cmd),
        .volume  (volume)
    );

    assign music_id     = id_q;
    assign start        = start_q;
    assign player_rst_n = prst_n_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_mp3_play_ctrl.sv
// Bench for mp3_play_ctrl: two instances (auto-advance with the full hold,
// pause-on-end with a short hold) driven in lockstep and compared every cycle
// against a behavioural model, plus directed scenario checks.
module tb_mp3_play_ctrl;

    localparam int NT     = 8;
    localparam int HOLD_A = 1000;
    localparam int HOLD_B = 16;

    logic clk_1M = 1'b0;
    always #5 clk_1M = ~clk_1M;

    logic rst, btn_play, btn_next, btn_prev, btn_vup, btn_vdn, track_end;

    mp3_play_ctrl_if bus_a ();
    mp3_play_ctrl_if bus_b ();

    logic [2:0]  mid [2];
    logic        stt [2];
    logic        prn [2];
    logic [7:0]  vol [2];
    logic [1:0]  sto [2];
    logic        req [2];
    logic [31:0] wrd [2];
    logic        ack [2];

    assign req[0] = bus_a.cmd_req;
    assign wrd[0] = bus_a.cmd_word;
    assign bus_a.cmd_ack = ack[0];
    assign req[1] = bus_b.cmd_req;
    assign wrd[1] = bus_b.cmd_word;
    assign bus_b.cmd_ack = ack[1];

    mp3_play_ctrl #(.SWITCH_HOLD(HOLD_A), .AUTO_NEXT(1'b1)) dut_a (
        .clk_1M(clk_1M), .rst(rst), .btn_play(btn_play), .btn_next(btn_next),
        .btn_prev(btn_prev), .btn_vup(btn_vup), .btn_vdn(btn_vdn), .track_end(track_end),
        .cmd(bus_a), .music_id(mid[0]), .start(stt[0]), .player_rst_n(prn[0]),
        .volume(vol[0]), .state_o(sto[0])
    );

    mp3_play_ctrl #(.SWITCH_HOLD(HOLD_B), .AUTO_NEXT(1'b0)) dut_b (
        .clk_1M(clk_1M), .rst(rst), .btn_play(btn_play), .btn_next(btn_next),
        .btn_prev(btn_prev), .btn_vup(btn_vup), .btn_vdn(btn_vdn), .track_end(track_end),
        .cmd(bus_b), .music_id(mid[1]), .start(stt[1]), .player_rst_n(prn[1]),
        .volume(vol[1]), .state_o(sto[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: mode 0 paused, 1 playing, 2 switching.
    int          m_mode [2];
    int          m_id   [2];
    int          m_left [2];
    int          m_vol  [2];
    bit          m_pend [2];
    bit          m_busy [2];
    logic [31:0] m_word [2];
    int          hold   [2] = '{HOLD_A, HOLD_B};
    bit          autonx [2] = '{1'b1, 1'b0};

    int wcnt [2] = '{0, 0};
    int ack_dly = 3;
    bit stray_en = 1'b0;
    int req_rises = 0;
    bit prev_req = 1'b0;
    int low_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int d, input bit rn, input bit p, input bit n, input bit pv,
                              input bit vu, input bit vd, input bit te, input bit ak);
        int nv;
        bit chg;
        if (!rn) begin
            m_mode[d] = 0; m_id[d] = 0; m_left[d] = 0; m_vol[d] = 32;
            m_pend[d] = 1'b1; m_busy[d] = 1'b0; m_word[d] = 32'h020B2020;
            return;
        end
        if (m_mode[d] == 2) begin
            m_left[d]--;
            if (m_left[d] == 0) m_mode[d] = 1;
        end else if (n) begin
            m_id[d] = (m_id[d] + 1) % NT; m_mode[d] = 2; m_left[d] = hold[d];
        end else if (pv) begin
            m_id[d] = (m_id[d] + NT - 1) % NT; m_mode[d] = 2; m_left[d] = hold[d];
        end else if (te && m_mode[d] == 1) begin
            if (autonx[d]) begin
                m_id[d] = (m_id[d] + 1) % NT; m_mode[d] = 2; m_left[d] = hold[d];
            end else begin
                m_mode[d] = 0;
            end
        end else if (p) begin
            m_mode[d] = 1 - m_mode[d];
        end
        nv = m_vol[d];
        if (vu && !vd) nv = (nv - 16 < 0) ? 0 : nv - 16;
        else if (vd && !vu) nv = (nv + 16 > 240) ? 240 : nv + 16;
        chg = (nv != m_vol[d]);
        if (m_busy[d]) begin
            if (ak) m_busy[d] = 1'b0;
        end else if (m_pend[d]) begin
            m_busy[d] = 1'b1;
            m_word[d] = {8'h02, 8'h0B, 8'(m_vol[d]), 8'(m_vol[d])};
            m_pend[d] = 1'b0;
        end
        if (chg) m_pend[d] = 1'b1;
        m_vol[d] = nv;
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            string t;
            t = (d == 0) ? "A" : "B";
            check({t, ".music_id"}, 32'(mid[d]), 32'(m_id[d]));
            check({t, ".state"}, 32'(sto[d]), 32'(m_mode[d]));
            check({t, ".start"}, 32'(stt[d]), 32'(m_mode[d] == 1));
            check({t, ".player_rst_n"}, 32'(prn[d]), 32'(m_mode[d] != 2));
            check({t, ".cmd_req"}, 32'(req[d]), 32'(m_busy[d]));
            check({t, ".cmd_word"}, wrd[d], m_word[d]);
            check({t, ".volume"}, 32'(vol[d]), 32'(m_vol[d]));
        end
    endtask

    // One clock: compare settled outputs, pick acks, drive inputs, advance the model.
    task automatic tick(input bit rn, input bit p, input bit n, input bit pv,
                        input bit vu, input bit vd, input bit te);
        bit ak [2];
        compare_all();
        if (req[0] && !prev_req) req_rises++;
        prev_req = req[0];
        if (!prn[0]) low_cnt++;
        for (int d = 0; d < 2; d++) begin
            ak[d] = 1'b0;
            if (req[d]) begin
                wcnt[d]++;
                if (wcnt[d] >= ack_dly) begin
                    ak[d] = 1'b1;
                    wcnt[d] = 0;
                end
            end else begin
                wcnt[d] = 0;
                ak[d] = stray_en && ($urandom_range(0, 7) == 0);
            end
        end
        rst = rn; btn_play = p; btn_next = n; btn_prev = pv;
        btn_vup = vu; btn_vdn = vd; track_end = te;
        ack[0] = ak[0]; ack[1] = ak[1];
        for (int d = 0; d < 2; d++) model_step(d, rn, p, n, pv, vu, vd, te, ak[d]);
        @(posedge clk_1M);
        @(negedge clk_1M);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_switch_done(input string tag);
        for (int i = 0; i < 2000; i++) begin
            if (sto[0] != 2'd2 && sto[1] != 2'd2) break;
            idle(1);
        end
        check(tag, 32'(sto[0]), 32'd1);
    endtask

    initial begin
        int r0;
        rst = 1'b0; btn_play = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
        btn_vup = 1'b0; btn_vdn = 1'b0; track_end = 1'b0;
        ack[0] = 1'b0; ack[1] = 1'b0;
        @(posedge clk_1M);
        @(negedge clk_1M);
        for (int d = 0; d < 2; d++) model_step(d, 1'b0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state and the initial volume write.
        check("rst_state", 32'(sto[0]), 32'd0);
        check("rst_start", 32'(stt[0]), 32'd0);
        check("rst_req", 32'(req[0]), 32'd0);
        idle(12);
        check("init_reqs", 32'(req_rises), 32'd1);
        check("init_word", wrd[0], 32'h020B2020);
        check("init_state", 32'(sto[0]), 32'd0);

        // Play, previous wrap 0 -> 7, next wrap 7 -> 0 with exact hold length.
        tick(1, 1, 0, 0, 0, 0, 0);
        check("play_start", 32'(stt[0]), 32'd1);
        tick(1, 0, 0, 1, 0, 0, 0);
        check("prev_wrap", 32'(mid[0]), 32'd7);
        wait_switch_done("prev_done");
        low_cnt = 0;
        tick(1, 0, 1, 0, 0, 0, 0);
        check("next_wrap", 32'(mid[0]), 32'd0);
        check("next_state", 32'(sto[0]), 32'd2);
        wait_switch_done("next_done");
        check("hold_len", 32'(low_cnt), 32'(HOLD_A));
        check("hold_start", 32'(stt[0]), 32'd1);

        // Advance to track 3, then track_end.
        repeat (3) begin
            tick(1, 0, 1, 0, 0, 0, 0);
            wait_switch_done("step_done");
        end
        check("id3", 32'(mid[0]), 32'd3);
        tick(1, 0, 0, 0, 0, 0, 1);
        check("tend_auto_id", 32'(mid[0]), 32'd4);
        check("tend_auto_st", 32'(sto[0]), 32'd2);
        check("tend_pause_id", 32'(mid[1]), 32'd3);
        check("tend_pause_st", 32'(sto[1]), 32'd0);
        wait_switch_done("tend_done");

        // next and play together while paused: SWITCH only.
        tick(1, 1, 0, 0, 0, 0, 0);
        check("paused", 32'(sto[0]), 32'd0);
        tick(1, 1, 1, 0, 0, 0, 0);
        check("np_state", 32'(sto[0]), 32'd2);
        check("np_id", 32'(mid[0]), 32'd5);
        wait_switch_done("np_done");

        // Volume up to saturation.
        idle(5);
        r0 = req_rises;
        tick(1, 0, 0, 0, 1, 0, 0); idle(8);
        check("vup1", 32'(vol[0]), 32'h10);
        tick(1, 0, 0, 0, 1, 0, 0); idle(8);
        check("vup2", 32'(vol[0]), 32'h00);
        tick(1, 0, 0, 0, 1, 0, 0); idle(8);
        check("vup3", 32'(vol[0]), 32'h00);
        check("sat_reqs", 32'(req_rises - r0), 32'd2);

        // Volume down while a request is outstanding.
        ack_dly = 8;
        r0 = req_rises;
        tick(1, 0, 0, 0, 0, 1, 0);
        idle(2);
        check("busy_req", 32'(req[0]), 32'd1);
        tick(1, 0, 0, 0, 0, 1, 0);
        idle(20);
        check("reissue_cnt", 32'(req_rises - r0), 32'd2);
        check("reissue_word", wrd[0], 32'h020B2020);

        // Reset during SWITCH with a request pending.
        tick(1, 0, 1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 1, 0);
        idle(2);
        check("pre_rst_req", 32'(req[0]), 32'd1);
        check("pre_rst_st", 32'(sto[0]), 32'd2);
        tick(0, 0, 0, 0, 0, 0, 0);
        check("rst2_id", 32'(mid[0]), 32'd0);
        check("rst2_state", 32'(sto[0]), 32'd0);
        check("rst2_prst", 32'(prn[0]), 32'd1);
        check("rst2_req", 32'(req[0]), 32'd0);
        check("rst2_vol", 32'(vol[0]), 32'h20);
        check("rst2_word", wrd[0], 32'h020B2020);
        ack_dly = 3;
        idle(1);
        check("rst2_reissue", 32'(req[0]), 32'd1);

        // Randomized traffic.
        stray_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) ack_dly = $urandom_range(1, 5);
            tick($urandom_range(0, 999) != 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 199) == 0,
                 $urandom_range(0, 199) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 19) == 0);
        end
        idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
